// File: rtl/led_share_pkg.sv
// Shared types and defaults for the LED share arbiter.
package led_share_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StOwn  = 2'd1,
        StGap  = 2'd2
    } state_e;

    localparam int unsigned LedWDefault    = 4;
    localparam logic [3:0]  IdlePatDefault = 4'h0;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: lowest requester index at or after rr_ptr, wrapping.
module rr_picker #(
    parameter int unsigned N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] rr_ptr,
    output logic                     valid,
    output logic [N_REQ-1:0]         winner
);

    logic [N_REQ-1:0] rot;
    logic [N_REQ-1:0] rot_oh;

    always_comb begin
        rot    = '0;
        winner = '0;
        // Rotate so rr_ptr lands at bit 0, isolate lowest set bit, rotate back.
        for (int unsigned i = 0; i < N_REQ; i++) begin
            rot[i] = req[(i + 32'(rr_ptr)) % N_REQ];
        end
        rot_oh = rot & (~rot + N_REQ'(1));
        for (int unsigned i = 0; i < N_REQ; i++) begin
            winner[(i + 32'(rr_ptr)) % N_REQ] = rot_oh[i];
        end
        valid = |req;
    end

endmodule

// File: rtl/led_share_arbiter.sv
// Round-robin owner of the user LEDs with a hold window per grant and a one-cycle gap
// between owners.
module led_share_arbiter
    import led_share_pkg::*;
#(
    parameter int unsigned       N_REQ       = 4,
    parameter int unsigned       LED_W       = LedWDefault,
    parameter int unsigned       HOLD_CYCLES = 1024,
    parameter logic [LED_W-1:0]  IDLE_PAT    = LED_W'(IdlePatDefault)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*LED_W-1:0] pattern,
    output logic [N_REQ-1:0]       grant,
    output logic [LED_W-1:0]       led,
    output logic                   busy
);

    localparam int unsigned     PTR_W    = $clog2(N_REQ);
    localparam int unsigned     CNT_W    = $clog2(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES - 1);

    state_e             state_q;
    logic [PTR_W-1:0]   owner_q;
    logic [PTR_W-1:0]   rr_ptr_q;
    logic [CNT_W-1:0]   hold_cnt_q;

    logic               pick_valid;
    logic [N_REQ-1:0]   pick_oh;
    logic [PTR_W-1:0]   pick_idx;
    logic [PTR_W-1:0]   owner_next;
    logic [LED_W-1:0]   own_pat;
    logic               others_pending;

    rr_picker #(
        .N_REQ (N_REQ)
    ) u_rr_picker (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .valid  (pick_valid),
        .winner (pick_oh)
    );

    always_comb begin
        pick_idx = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (pick_oh[i]) begin
                pick_idx = PTR_W'(i);
            end
        end
        owner_next     = (owner_q == PTR_W'(N_REQ - 1)) ? '0 : owner_q + PTR_W'(1);
        own_pat        = pattern[owner_q*LED_W +: LED_W];
        others_pending = |(req & ~grant);
    end

    assign busy = |grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            grant      <= '0;
            led        <= IDLE_PAT;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            hold_cnt_q <= '0;
        end else begin
            unique case (state_q)
                StIdle, StGap: begin
                    led <= IDLE_PAT;
                    if (pick_valid) begin
                        state_q    <= StOwn;
                        grant      <= pick_oh;
                        owner_q    <= pick_idx;
                        hold_cnt_q <= '0;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StOwn: begin
                    // A drop wins over a coincident hold expiry.
                    if (!req[owner_q] || (hold_cnt_q == HOLD_MAX && others_pending)) begin
                        state_q  <= StGap;
                        grant    <= '0;
                        led      <= IDLE_PAT;
                        rr_ptr_q <= owner_next;
                    end else begin
                        led        <= own_pat;
                        hold_cnt_q <= (hold_cnt_q == HOLD_MAX) ? '0 : hold_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                    grant   <= '0;
                    led     <= IDLE_PAT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_share_arbiter.sv
// Scoreboard bench for led_share_arbiter against a behavioural ownership model.
module tb_led_share_arbiter;

    localparam int unsigned N    = 4;
    localparam int unsigned LW   = 4;
    localparam int unsigned HOLD = 8;
    localparam logic [3:0]  IDLE = 4'h0;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  req;
    logic [N*LW-1:0] pattern;
    logic [N-1:0]  grant;
    logic [LW-1:0] led;
    logic          busy;

    int n_tests = 0;
    int n_fail  = 0;

    // {grant, led, busy}
    logic [8:0] exp_q[$];

    int         m_owner;
    int         m_held;
    int         m_rr;
    logic [3:0] m_led;

    led_share_arbiter #(
        .N_REQ       (N),
        .LED_W       (LW),
        .HOLD_CYCLES (HOLD),
        .IDLE_PAT    (IDLE)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .pattern (pattern),
        .grant   (grant),
        .led     (led),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_held  = 0;
        m_rr    = 0;
        m_led   = IDLE;
    endtask

    // One clock of ownership rules: expected outputs after the edge that samples r/p.
    task automatic model_step(input logic [3:0] r, input logic [15:0] p);
        logic [3:0] others;
        logic [3:0] g;
        if (m_owner >= 0) begin
            others = r;
            others[m_owner] = 1'b0;
            if (!r[m_owner] || (m_held == HOLD - 1 && others != 4'b0)) begin
                m_rr    = (m_owner + 1) % N;
                m_owner = -1;
                m_led   = IDLE;
            end else begin
                m_held = (m_held + 1) % HOLD;
                m_led  = p[m_owner*LW +: LW];
            end
        end else begin
            m_led = IDLE;
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (m_rr + k) % N;
                if (r[idx] && m_owner < 0) begin
                    m_owner = idx;
                    m_held  = 0;
                end
            end
        end
        g = 4'b0;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        exp_q.push_back({g, m_led, (g != 4'b0)});
    endtask

    task automatic drive(input logic [3:0] r, input logic [15:0] p);
        @(negedge clk);
        req     = r;
        pattern = p;
        model_step(r, p);
    endtask

    // Monitor: compare one expected entry just after each active edge.
    initial begin
        logic [8:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("grant", 32'(grant), 32'(e[8:5]));
                check("led", 32'(led), 32'(e[4:1]));
                check("busy", 32'(busy), 32'(e[0]));
            end
            if (rst_n) begin
                check("grant_onehot0", 32'($onehot0(grant)), 32'd1);
                check("busy_eq_or_grant", 32'(busy), 32'(|grant));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] r;
        rst_n   = 1'b0;
        req     = '0;
        pattern = '0;
        model_reset();
        #3;
        check("por_grant", 32'(grant), 32'd0);
        check("por_led", 32'(led), 32'(IDLE));
        check("por_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // All requesting from IDLE: rotation 0,1,2,3,0 with gaps.
        for (int i = 0; i < 48; i++) drive(4'b1111, 16'($urandom));
        for (int i = 0; i < 3; i++) drive(4'b0000, 16'($urandom));

        // Lone requester 2: held through renewals with no gap.
        for (int i = 0; i < 24; i++) drive(4'b0100, 16'h0A00);
        for (int i = 0; i < 3; i++) drive(4'b0000, 16'h0000);

        // Owner 1 drops early while 3 waits.
        drive(4'b0010, 16'h1234);
        drive(4'b1010, 16'h5678);
        drive(4'b1010, 16'h9ABC);
        for (int i = 0; i < 4; i++) drive(4'b1000, 16'hD0EF);
        for (int i = 0; i < 3; i++) drive(4'b0000, 16'h0000);

        // Drop coinciding with hold expiry, nobody else waiting.
        for (int i = 0; i < 8; i++) drive(4'b0001, 16'h0007);
        for (int i = 0; i < 3; i++) drive(4'b0000, 16'h0007);

        // Owner pattern changes mid-grant.
        for (int i = 0; i < 4; i++) drive(4'b0001, 16'h0003);
        for (int i = 0; i < 4; i++) drive(4'b0001, 16'h000C);
        for (int i = 0; i < 3; i++) drive(4'b0000, 16'h0000);

        // Asynchronous reset mid-grant.
        for (int i = 0; i < 4; i++) drive(4'b0100, 16'h0B00);
        @(negedge clk);
        #2;
        check("pre_reset_grant", 32'(grant), 32'b0100);
        rst_n = 1'b0;
        req   = '0;
        #1;
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_led", 32'(led), 32'(IDLE));
        check("rst_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Pointer back at 0 after reset.
        for (int i = 0; i < 12; i++) drive(4'b1111, 16'($urandom));

        // Random request churn with live patterns.
        r = 4'b0000;
        for (int i = 0; i < 600; i++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 9) == 0) r[b] = ~r[b];
            end
            drive(r, 16'($urandom));
        end

        repeat (3) @(posedge clk);
        #2;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
